// File: rtl/uart_pkg.sv
// Common UART definitions shared by the receiver, the transmitter and the receive FIFO.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: circular buffer with wrap-bit pointers and a registered fill count.
// Build option UART_RX_FIFO_DROP_EN: never back-pressure; drop bytes when full and flag overflow.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int DEPTH     = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_BITS-1:0]       in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DATA_BITS-1:0]       out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [PW-1:0]        wr_q, wr_d;
   logic [PW-1:0]        rd_q, rd_d;
   logic [PW-1:0]        cnt_q, cnt_d;
   logic                 empty, full, push, pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign pop   = !empty && out_ready;

`ifdef UART_RX_FIFO_DROP_EN
   logic drop;
   logic ovf_q, ovf_d;

   // A pop on the same edge frees the slot, so a full-FIFO push is still taken.
   assign in_ready = 1'b1;
   assign push     = in_valid && (!full || pop);
   assign drop     = in_valid && full && !pop;

   always_comb begin
      ovf_d = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (overflow_clr)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else
         ovf_q <= ovf_d;
   end

   assign overflow = ovf_q;
`else
   logic unused_clr;

   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign overflow   = 1'b0;
   assign unused_clr = overflow_clr;
`endif

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push)
         wr_d = wr_q + PW'(1);
      if (pop)
         rd_d = rd_q + PW'(1);
      cnt_d = wr_d - rd_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is deliberately left out of reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem_q[wr_q[AW-1:0]] <= in_data;
   end

   assign out_data  = mem_q[rd_q[AW-1:0]];
   assign out_valid = !empty;
   assign count     = cnt_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int DB    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DB-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DB-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [4:0]    count;
   logic          overflow;
   logic          overflow_clr = 1'b0;

   int            n_checks = 0;
   int            n_err = 0;

   logic [DB-1:0] q[$];
   bit            exp_ovf = 1'b0;

   uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .overflow(overflow), .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; advances the model by the FIFO rules, returns whether the push was taken.
   task automatic step(input bit v, input logic [DB-1:0] d, input bit r,
                       input bit clr, input bit rs, output bit acc);
      bit do_pop, do_push;
      in_valid = v; in_data = d; out_ready = r; overflow_clr = clr; rst = rs;
      do_pop = r && (q.size() > 0);
`ifdef UART_RX_FIFO_DROP_EN
      do_push = v && ((q.size() < DEPTH) || do_pop);
`else
      do_push = v && (q.size() < DEPTH);
`endif
      @(posedge clk); #1;
      if (rs) begin
         q.delete();
         exp_ovf = 1'b0;
         acc = 1'b0;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
`ifdef UART_RX_FIFO_DROP_EN
         if (v && !do_push) exp_ovf = 1'b1;
         else if (clr) exp_ovf = 1'b0;
`endif
         acc = do_push;
      end
      in_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      bit acc;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
      n_checks++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
      n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_single();
      bit acc;
      step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, acc);
      n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", out_valid); end
      n_checks++; if (out_data !== 8'h41) begin n_err++; $display("FAIL single_data: got %0h exp 41", out_data); end
      n_checks++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d exp 1", count); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b exp 0", out_valid); end
   endtask

   task automatic test_fill_drain();
      bit acc;
      for (int i = 0; i < DEPTH; i++) step(1'b1, DB'(i), 1'b0, 1'b0, 1'b0, acc);
      n_checks++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d exp 16", count); end
`ifdef UART_RX_FIFO_DROP_EN
      n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_in_ready: got %b exp 1", in_ready); end
`else
      n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b exp 0", in_ready); end
      // Held byte while full must not enter or disturb storage.
      step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, acc);
      n_checks++; if (count !== 5'd16) begin n_err++; $display("FAIL backpress_count: got %0d exp 16", count); end
      n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL backpress_overflow: got %b exp 0", overflow); end
`endif
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== DB'(i)) begin
            n_err++; $display("FAIL drain_order[%0d]: got v=%b d=%0h exp v=1 d=%0h", i, out_valid, out_data, i);
         end
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      end
      n_checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL drain_empty: got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count); end
   endtask

   task automatic test_random_stalls();
      bit acc, v, r;
      int sent = 0;
      int cyc = 0;
      while ((sent < 40 || q.size() > 0) && cyc < 3000) begin
         v = (sent < 40) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         if (sent >= 40) r = 1'b1;
         step(v, DB'($urandom), r, 1'b0, 1'b0, acc);
         if (acc) sent++;
         cyc++;
         n_checks++;
         if (count !== 5'(q.size()) || count > 5'd16) begin
            n_err++; $display("FAIL rand_count: got %0d exp %0d", count, q.size());
         end
         n_checks++;
         if (out_valid !== (q.size() > 0) || (q.size() > 0 && out_data !== q[0])) begin
            n_err++; $display("FAIL rand_head: got v=%b d=%0h exp v=%b d=%0h", out_valid, out_data,
                              q.size() > 0, (q.size() > 0) ? q[0] : 8'h00);
         end
         n_checks++;
         if (overflow !== exp_ovf) begin n_err++; $display("FAIL rand_overflow: got %b exp %b", overflow, exp_ovf); end
      end
      n_checks++; if (cyc >= 3000) begin n_err++; $display("FAIL rand_timeout: got %0d cycles exp < 3000", cyc); end
   endtask

   task automatic test_back_to_back();
      bit acc;
      for (int i = 0; i < 5; i++) step(1'b1, DB'($urandom), 1'b0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (out_data !== q[0]) begin n_err++; $display("FAIL b2b_data[%0d]: got %0h exp %0h", i, out_data, q[0]); end
         step(1'b1, DB'($urandom), 1'b1, 1'b0, 1'b0, acc);
         n_checks++;
         if (count !== 5'd5) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d exp 5", i, count); end
      end
      while (q.size() > 0) begin
         n_checks++;
         if (out_data !== q[0]) begin n_err++; $display("FAIL b2b_drain: got %0h exp %0h", out_data, q[0]); end
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      end
   endtask

`ifdef UART_RX_FIFO_DROP_EN
   task automatic test_drop();
      bit acc;
      for (int i = 0; i < DEPTH; i++) step(1'b1, DB'(8'h10 + i), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, acc);
      n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_overflow: got %b exp 1", overflow); end
      n_checks++; if (count !== 5'd16) begin n_err++; $display("FAIL drop_count: got %0d exp 16", count); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL drop_clr: got %b exp 0", overflow); end
      step(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, acc);
      n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_over_clr: got %b exp 1", overflow); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, acc);
      n_checks++; if (overflow !== 1'b0 || count !== 5'd16) begin n_err++; $display("FAIL drop_pushpop: got ovf=%b cnt=%0d exp ovf=0 cnt=16", overflow, count); end
      while (q.size() > 0) begin
         n_checks++;
         if (out_data !== q[0]) begin n_err++; $display("FAIL drop_drain: got %0h exp %0h", out_data, q[0]); end
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      end
   endtask
`endif

   task automatic test_reset_mid();
      bit acc;
      for (int i = 0; i < 7; i++) step(1'b1, DB'($urandom), 1'b0, 1'b0, 1'b0, acc);
      n_checks++; if (count !== 5'd7) begin n_err++; $display("FAIL mid_pre_count: got %0d exp 7", count); end
      step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, acc);
      n_checks++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
         n_err++; $display("FAIL mid_reset: got cnt=%0d v=%b ovf=%b exp 0 0 0", count, out_valid, overflow);
      end
      n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b exp 1", in_ready); end
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, acc);
      n_checks++; if (count !== 5'd1 || out_data !== 8'h3C) begin
         n_err++; $display("FAIL mid_push: got cnt=%0d d=%0h exp 1 3c", count, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_random_stalls();
      test_back_to_back();
`ifdef UART_RX_FIFO_DROP_EN
      test_drop();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_uart_rx_fifo
